axis_to_pkt: RTL and testbench

AXIS_TO_PKT -- requirements
Module: axis_to_pkt

---
 rtl/axis_to_pkt.sv | 186 ++++++++++++++++++
 tb/tb_axis_to_pkt.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_pkt.sv
// AXI-Stream byte stream to GMII transmit framer: preamble/SFD, payload,
// zero padding to a minimum length, optional CRC-32 FCS, underrun abort and IFG.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line quiet, waiting for a beat to be offered
// PREAMBLE | sending PREAMBLE_LEN x 0x55 followed by the 0xD5 SFD
// DATA     | forwarding accepted beats one per cycle
// PAD      | sending 0x00 until the frame reaches MIN_FRAME bytes
// FCS      | sending the complemented CRC, least-significant byte first
// ABORT    | single tx_er cycle marking a frame cut short by underrun
// DROP     | discarding the rest of the aborted frame up to tlast
// IFG      | IFG_LEN quiet cycles before the next frame may start
module axis_to_pkt #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int ADD_FCS      = 1,
   parameter int IFG_LEN      = 12
) (
   input  logic       axis_aclk,
   input  logic       axis_aresetn,
   input  logic [7:0] axis_tdata,
   input  logic       axis_tuser,
   input  logic       axis_tlast,
   input  logic       axis_tvalid,
   output logic       axis_tready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       tx_er,
   output logic       tx_underrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_ABORT, S_DROP, S_IFG
   } state_t;

   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
   localparam logic [15:0] PRE_LOAD = 16'(PREAMBLE_LEN);
   localparam logic [15:0] IFG_LOAD = (IFG_LEN > 0) ? 16'(IFG_LEN - 1) : 16'd0;
   localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
   localparam logic [10:0] CNT_MAX  = 11'h7FF;
   // Where the frame body goes once data and pad are complete.
   localparam state_t      BODY_DONE_STATE = (ADD_FCS != 0) ? S_FCS : S_IFG;
   localparam logic [15:0] BODY_DONE_LOAD  = (ADD_FCS != 0) ? 16'd3 : IFG_LOAD;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [10:0] cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic        underrun_q, underrun_d;
   logic [10:0] cnt_inc;
   logic        short_frame;

   function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
   assign short_frame = ({1'b0, cnt_inc} < MIN_LEN);
   assign axis_tready = axis_aresetn && ((state_q == S_DATA) || (state_q == S_DROP));

   assign tx_data     = tx_data_q;
   assign tx_en       = tx_en_q;
   assign tx_er       = tx_er_q;
   assign tx_underrun = underrun_q;

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      cnt_d      = cnt_q;
      crc_d      = crc_q;
      tx_data_d  = 8'h00;
      tx_en_d    = 1'b0;
      tx_er_d    = 1'b0;
      underrun_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (axis_tvalid) begin
               state_d = S_PREAMBLE;
               timer_d = PRE_LOAD;
            end
         end
         S_PREAMBLE: begin
            cnt_d   = 11'd0;
            crc_d   = CRC_INIT;
            tx_en_d = 1'b1;
            if (timer_q != 16'd0) begin
               tx_data_d = 8'h55;
               timer_d   = timer_q - 16'd1;
            end else begin
               tx_data_d = 8'hD5;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            tx_en_d = 1'b1;
            if (axis_tvalid) begin
               tx_data_d = axis_tdata;
               tx_er_d   = axis_tuser;
               crc_d     = crc_next(crc_q, axis_tdata);
               cnt_d     = cnt_inc;
               if (axis_tlast) begin
                  if (short_frame) begin
                     state_d = S_PAD;
                  end else begin
                     state_d = BODY_DONE_STATE;
                     timer_d = BODY_DONE_LOAD;
                  end
               end
            end else begin
               // Starved mid-frame: the error symbol goes out right away so tx_en never gaps.
               tx_er_d    = 1'b1;
               underrun_d = 1'b1;
               state_d    = S_ABORT;
            end
         end
         S_PAD: begin
            tx_en_d = 1'b1;
            crc_d   = crc_next(crc_q, 8'h00);
            cnt_d   = cnt_inc;
            if (!short_frame) begin
               state_d = BODY_DONE_STATE;
               timer_d = BODY_DONE_LOAD;
            end
         end
         S_FCS: begin
            tx_en_d   = 1'b1;
            tx_data_d = ~crc_q[7:0];
            crc_d     = {8'hFF, crc_q[31:8]};
            if (timer_q == 16'd0) begin
               state_d = S_IFG;
               timer_d = IFG_LOAD;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_ABORT: state_d = S_DROP;
         S_DROP: begin
            if (axis_tvalid && axis_tlast) begin
               state_d = S_IFG;
               timer_d = IFG_LOAD;
            end
         end
         S_IFG: begin
            if (timer_q == 16'd0) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         state_q    <= S_IDLE;
         timer_q    <= 16'd0;
         cnt_q      <= 11'd0;
         crc_q      <= CRC_INIT;
         tx_data_q  <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         tx_data_q  <= tx_data_d;
         tx_en_q    <= tx_en_d;
         tx_er_q    <= tx_er_d;
         underrun_q <= underrun_d;
      end
   end

endmodule

// File: tb/tb_axis_to_pkt.sv
// Bench for axis_to_pkt: directed frames against a queue of expected GMII cycles
// built from the framing rules, plus literal checks of lengths and a known CRC.
module tb_axis_to_pkt;

   localparam int PRE  = 7;
   localparam int MINF = 60;
   localparam int IFG  = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] tdata;
   logic       tuser, tlast, tvalid, tready;
   logic [7:0] tx_data;
   logic       tx_en, tx_er, tx_und;

   logic [7:0] b_tdata;
   logic       b_tuser, b_tlast, b_tvalid, b_tready;
   logic [7:0] b_tx_data;
   logic       b_tx_en, b_tx_er, b_tx_und;

   axis_to_pkt dut (
      .axis_aclk(clk), .axis_aresetn(rst_n), .axis_tdata(tdata), .axis_tuser(tuser),
      .axis_tlast(tlast), .axis_tvalid(tvalid), .axis_tready(tready),
      .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er), .tx_underrun(tx_und)
   );

   axis_to_pkt #(.MIN_FRAME(0)) dut_b (
      .axis_aclk(clk), .axis_aresetn(rst_n), .axis_tdata(b_tdata), .axis_tuser(b_tuser),
      .axis_tlast(b_tlast), .axis_tvalid(b_tvalid), .axis_tready(b_tready),
      .tx_data(b_tx_data), .tx_en(b_tx_en), .tx_er(b_tx_er), .tx_underrun(b_tx_und)
   );

   typedef struct packed {
      logic       en;
      logic       er;
      logic       und;
      logic       isd;
      logic [7:0] data;
   } item_t;

   item_t      exp_q[$];
   int         acc_q[$];
   int         burst_q[$];
   logic [7:0] pay[$];
   logic       usr[$];
   logic [7:0] got_b[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   bit         synced = 1'b0;
   int         run_len = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] crc_bit_step(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ b[i];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB88320;
      end
      return c;
   endfunction

   function automatic void push(input logic en, input logic er, input logic und,
                                input logic isd, input logic [7:0] d);
      item_t it;
      it.en = en; it.er = er; it.und = und; it.isd = isd; it.data = d;
      exp_q.push_back(it);
   endfunction

   function automatic void push_preamble();
      for (int i = 0; i < PRE; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
      push(1'b1, 1'b0, 1'b0, 1'b0, 8'hD5);
   endfunction

   // Expected line activity for pay[0..n-1]; full=0 models a frame cut by reset.
   function automatic void push_frame(input int n, input bit full, input int tail);
      logic [31:0] crc;
      int          pad;
      crc = 32'hFFFFFFFF;
      push_preamble();
      for (int i = 0; i < n; i++) begin
         push(1'b1, usr[i], 1'b0, 1'b1, pay[i]);
         crc = crc_bit_step(crc, pay[i]);
      end
      if (full) begin
         pad = (n < MINF) ? MINF - n : 0;
         for (int i = 0; i < pad; i++) begin
            push(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            crc = crc_bit_step(crc, 8'h00);
         end
         crc = ~crc;
         for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 1'b0, 1'b0, crc[8*k +: 8]);
         for (int i = 0; i < tail; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
   endfunction

   // k bytes sent, then a g-cycle stall, then n_disc beats thrown away, IFG, idle.
   function automatic void push_underrun(input int k, input int g, input int n_disc);
      push_preamble();
      for (int i = 0; i < k; i++) push(1'b1, usr[i], 1'b0, 1'b1, pay[i]);
      push(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < (g - 1) + n_disc + IFG + 1; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endfunction

   always @(negedge clk) begin
      item_t e;
      int    a;
      if (exp_q.size() > 0 && (synced || tx_en === 1'b1)) begin
         e = exp_q.pop_front();
         synced = (exp_q.size() > 0);
         check("tx_out{en,er,und,data}", {21'h0, tx_en, tx_er, tx_und, tx_data},
               {21'h0, e.en, e.er, e.und, e.data});
         if (e.isd) begin
            a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
            check("data_latency_cycle", cyc, a + 1);
         end
      end else if (tx_en === 1'b1) begin
         check("unexpected_tx_en", {31'h0, tx_en}, 32'h0);
      end
      if (tx_en === 1'b1) begin
         run_len++;
      end else if (run_len > 0) begin
         burst_q.push_back(run_len);
         run_len = 0;
      end
   end

   task automatic send_beat(input bit sel, input logic [7:0] d, input logic u,
                            input logic l, input bit stamp);
      int   n;
      logic rdy;
      @(negedge clk);
      #1;
      if (sel) begin
         b_tvalid = 1'b1; b_tdata = d; b_tuser = u; b_tlast = l;
      end else begin
         tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
      end
      #1;
      rdy = sel ? b_tready : tready;
      n = 0;
      while (rdy !== 1'b1 && n < 400) begin
         @(negedge clk);
         #2;
         rdy = sel ? b_tready : tready;
         n++;
      end
      if (rdy !== 1'b1) check("beat_accept_timeout", {31'h0, rdy}, 32'h1);
      else if (stamp) acc_q.push_back(cyc);
      @(posedge clk);
   endtask

   task automatic send_range(input int from, input int to, input bit last_at_end, input bit stamp);
      for (int i = from; i <= to; i++) send_beat(1'b0, pay[i], usr[i], last_at_end && (i == to), stamp);
   endtask

   task automatic stall(input int g);
      @(negedge clk);
      #1 tvalid = 1'b0;
      repeat (g) @(posedge clk);
   endtask

   task automatic load_payload(input int n, input int base, input int step, input int err_idx);
      pay.delete();
      usr.delete();
      for (int i = 0; i < n; i++) begin
         pay.push_back(8'(base + step * i));
         usr.push_back(i == err_idx);
      end
   endtask

   initial begin
      repeat (30000) @(posedge clk);
      $display("FAIL watchdog: bench did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] c;
      int          exp_burst[7];
      int          w;
      exp_burst = '{76, 72, 14, 72, 72, 73, 16};
      rst_n = 1'b0;
      tvalid = 1'b0; tdata = 8'h00; tuser = 1'b0; tlast = 1'b0;
      b_tvalid = 1'b0; b_tdata = 8'h00; b_tuser = 1'b0; b_tlast = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_en", {31'h0, tx_en}, 32'h0);
      check("rst_tx_er", {31'h0, tx_er}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_underrun", {31'h0, tx_und}, 32'h0);
      check("rst_tready", {31'h0, tready}, 32'h0);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) c = crc_bit_step(c, 8'(8'h31 + i));
      check("model_crc_123456789", ~c, 32'hCBF43926);
      #1 rst_n = 1'b1;

      load_payload(64, 0, 1, -1);         // 0x00..0x3F, no pad
      push_frame(64, 1'b1, IFG + 1);
      send_range(0, 63, 1'b1, 1'b1);

      load_payload(10, 8'hA0, 1, 2);      // short frame, byte 3 flagged
      push_frame(10, 1'b1, IFG + 1);
      send_range(0, 9, 1'b1, 1'b1);

      load_payload(20, 8'hC0, 1, -1);     // underrun after byte 5
      push_underrun(5, 3, 15);
      send_range(0, 4, 1'b0, 1'b1);
      stall(3);
      send_range(5, 19, 1'b1, 1'b0);

      load_payload(60, 0, 3, -1);         // exactly MIN_FRAME
      push_frame(60, 1'b1, IFG + 1);
      send_range(0, 59, 1'b1, 1'b1);

      load_payload(1, 8'h7E, 0, -1);      // single byte, 59 pad
      push_frame(1, 1'b1, IFG + 1);
      send_range(0, 0, 1'b1, 1'b1);

      load_payload(61, 255, -1, -1);      // one past MIN_FRAME
      push_frame(61, 1'b1, IFG + 1);
      send_range(0, 60, 1'b1, 1'b1);

      load_payload(20, 8'h10, 1, -1);     // reset lands after byte 8
      push_frame(8, 1'b0, 0);
      send_range(0, 7, 1'b0, 1'b1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("reset_tready", {31'h0, tready}, 32'h0);
      @(posedge clk);
      #1;
      check("reset_drop_tx_en", {31'h0, tx_en}, 32'h0);
      check("reset_drop_tx_er", {31'h0, tx_er}, 32'h0);
      check("reset_drop_tx_data", {24'h0, tx_data}, 32'h0);
      tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;

      fork
         begin
            for (int i = 0; i < 9; i++) send_beat(1'b1, 8'(8'h31 + i), 1'b0, i == 8, 1'b0);
            @(negedge clk);
            #1 b_tvalid = 1'b0;
         end
         begin
            w = 0;
            @(negedge clk);
            while (b_tx_en !== 1'b1 && w < 200) begin
               @(negedge clk);
               w++;
            end
            w = 0;
            while (b_tx_en === 1'b1 && w < 64) begin
               got_b.push_back(b_tx_data);
               @(negedge clk);
               w++;
            end
         end
      join
      check("crc_frame_len", got_b.size(), 32'd21);
      while (got_b.size() < 21) got_b.push_back(8'h00);
      check("crc_frame_sfd", {24'h0, got_b[7]}, 32'hD5);
      check("crc_frame_first", {24'h0, got_b[8]}, 32'h31);
      check("crc_fcs0", {24'h0, got_b[17]}, 32'h26);
      check("crc_fcs1", {24'h0, got_b[18]}, 32'h39);
      check("crc_fcs2", {24'h0, got_b[19]}, 32'hF4);
      check("crc_fcs3", {24'h0, got_b[20]}, 32'hCB);

      repeat (5) @(negedge clk);
      check("expected_queue_drained", exp_q.size(), 32'd0);
      check("accept_stamps_used", acc_q.size(), 32'd0);
      check("burst_count", burst_q.size(), 32'd7);
      for (int i = 0; i < 7; i++)
         check("burst_len", (i < burst_q.size()) ? burst_q[i] : -1, exp_burst[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
